// File: rtl/sobel_window_engine_if.sv
// ---------------------------------------------------------------------------
// sobel_window_engine_if
//   Bundles the control, frame-buffer read and result-stream signals of the
//   Sobel window engine.
//
//   Control      : i_START (pulse), o_BUSY, o_DONE (pulse)
//   Read bus     : o_READ strobe, o_ADDRESS {row[7:0], col[8:0]},
//                  i_DATA returned one cycle after the strobe
//   Result stream: o_PIX_VALID / i_PIX_READY handshake, o_PIX_DATA magnitude,
//                  o_PIX_ADDR {row[7:0], col[8:0]} of the result pixel
//
//   master : engine side
//   slave  : environment side (start source, frame buffer, edge-map writer)
// ---------------------------------------------------------------------------
interface sobel_window_engine_if #(
  parameter int DATA_W = 12
);
  logic              i_START;
  logic              o_BUSY;
  logic              o_DONE;
  logic              o_READ;
  logic [16:0]       o_ADDRESS;
  logic [DATA_W-1:0] i_DATA;
  logic              o_PIX_VALID;
  logic              i_PIX_READY;
  logic [DATA_W-1:0] o_PIX_DATA;
  logic [16:0]       o_PIX_ADDR;

  modport master (
    input  i_START, i_DATA, i_PIX_READY,
    output o_BUSY, o_DONE, o_READ, o_ADDRESS,
           o_PIX_VALID, o_PIX_DATA, o_PIX_ADDR
  );

  modport slave (
    output i_START, i_DATA, i_PIX_READY,
    input  o_BUSY, o_DONE, o_READ, o_ADDRESS,
           o_PIX_VALID, o_PIX_DATA, o_PIX_ADDR
  );
endinterface

// File: rtl/sobel_window_engine.sv
// ---------------------------------------------------------------------------
// sobel_window_engine
//   Walks an IMG_W x IMG_H frame in raster order. For every interior pixel it
//   reads the 3x3 neighbourhood from the frame buffer (nine back-to-back
//   reads), accumulates the Sobel Gx/Gy sums, and emits |Gx|+|Gy| saturated
//   to DATA_W bits together with the pixel address. Border pixels emit 0
//   without touching the frame buffer.
//
//   Ports
//     i_CLK  : clock, rising edge
//     i_RST  : synchronous active-high reset
//     bus    : sobel_window_engine_if.master
//              i_START/o_BUSY/o_DONE   frame-pass control
//              o_READ/o_ADDRESS/i_DATA frame-buffer read port (1-cycle latency)
//              o_PIX_*/i_PIX_READY     result stream, valid/ready
// ---------------------------------------------------------------------------
module sobel_window_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 12
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  sobel_window_engine_if.master  bus
);

  localparam int ROW_W = 8;
  localparam int COL_W = 9;
  localparam int ACC_W = DATA_W + 3;  // holds +/-4*(2^DATA_W-1)
  localparam int MAG_W = DATA_W + 4;  // |Gx|+|Gy| without overflow

  localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    DRAIN,
    CALC,
    OUT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col;
  logic [3:0]               k;
  logic signed [ACC_W-1:0]  gx_acc;
  logic signed [ACC_W-1:0]  gy_acc;
  logic [DATA_W-1:0]        res_data;

  // Read issued in the previous cycle; its data is on i_DATA this cycle.
  logic                     vld_p0;
  logic [3:0]               tap_p0;

  logic                     is_border;
  logic                     is_last;
  logic                     handshake;
  logic [3:0]               tap_off;
  logic [ROW_W-1:0]         rd_row;
  logic [COL_W-1:0]         rd_col;

  // Window offset of tap k: {row offset, col offset}, each 0..2, row-major.
  function automatic logic [3:0] tap_offset(input logic [3:0] tap);
    case (tap)
      4'd0:    return {2'd0, 2'd0};
      4'd1:    return {2'd0, 2'd1};
      4'd2:    return {2'd0, 2'd2};
      4'd3:    return {2'd1, 2'd0};
      4'd4:    return {2'd1, 2'd1};
      4'd5:    return {2'd1, 2'd2};
      4'd6:    return {2'd2, 2'd0};
      4'd7:    return {2'd2, 2'd1};
      4'd8:    return {2'd2, 2'd2};
      default: return 4'd0;
    endcase
  endfunction

  // Weighted contribution of one tap; weights are 0, +/-1, +/-2 so a shift
  // and negate replace a multiplier.
  function automatic logic signed [ACC_W-1:0] sobel_term(
    input logic [3:0]        tap,
    input logic [DATA_W-1:0] pix,
    input logic              y_kernel
  );
    logic signed [ACC_W-1:0] p1;
    logic signed [ACC_W-1:0] p2;
    p1 = signed'({{(ACC_W-DATA_W){1'b0}}, pix});
    p2 = p1 <<< 1;
    if (!y_kernel) begin
      case (tap)
        4'd0, 4'd6: return -p1;
        4'd2, 4'd8: return p1;
        4'd3:       return -p2;
        4'd5:       return p2;
        default:    return '0;
      endcase
    end else begin
      case (tap)
        4'd0, 4'd2: return -p1;
        4'd1:       return -p2;
        4'd6, 4'd8: return p1;
        4'd7:       return p2;
        default:    return '0;
      endcase
    end
  endfunction

  // |gx|+|gy| clamped to the largest DATA_W value.
  function automatic logic [DATA_W-1:0] sat_mag(
    input logic signed [ACC_W-1:0] gx,
    input logic signed [ACC_W-1:0] gy
  );
    logic signed [ACC_W-1:0] ax;
    logic signed [ACC_W-1:0] ay;
    logic [MAG_W-1:0]        mag;
    ax  = gx[ACC_W-1] ? -gx : gx;
    ay  = gy[ACC_W-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    if (mag > SAT_MAX) return {DATA_W{1'b1}};
    return mag[DATA_W-1:0];
  endfunction

  assign is_border = (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                     (col == '0) || (col == COL_W'(IMG_W - 1));
  assign is_last   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign handshake = (state == OUT) && bus.i_PIX_READY;

  assign tap_off = tap_offset(k);
  assign rd_row  = row + ROW_W'(tap_off[3:2]) - ROW_W'(1);
  assign rd_col  = col + COL_W'(tap_off[1:0]) - COL_W'(1);

  assign bus.o_PIX_DATA = res_data;
  assign bus.o_PIX_ADDR = {row, col};

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n         = state;
    bus.o_BUSY      = 1'b1;
    bus.o_DONE      = 1'b0;
    bus.o_READ      = 1'b0;
    bus.o_ADDRESS   = '0;
    bus.o_PIX_VALID = 1'b0;
    case (state)
      IDLE: begin
        bus.o_BUSY = 1'b0;
        if (bus.i_START) state_n = CHECK;
      end
      CHECK: state_n = is_border ? OUT : FETCH;
      FETCH: begin
        bus.o_READ    = 1'b1;
        bus.o_ADDRESS = {rd_row, rd_col};
        if (k == 4'd8) state_n = DRAIN;
      end
      DRAIN: state_n = CALC;
      CALC:  state_n = OUT;
      OUT: begin
        bus.o_PIX_VALID = 1'b1;
        if (handshake) state_n = is_last ? DONE : CHECK;
      end
      DONE: begin
        bus.o_BUSY = 1'b0;
        bus.o_DONE = 1'b1;
        state_n    = IDLE;
      end
      default: begin
        bus.o_BUSY = 1'b0;
        state_n    = IDLE;
      end
    endcase
  end

  // --- stage p0: read strobe -> captured tap, accumulate into Gx/Gy -------
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      row      <= '0;
      col      <= '0;
      k        <= '0;
      gx_acc   <= '0;
      gy_acc   <= '0;
      res_data <= '0;
      vld_p0   <= 1'b0;
      tap_p0   <= '0;
    end else begin
      vld_p0 <= (state == FETCH);
      tap_p0 <= k;
      case (state)
        IDLE: begin
          if (bus.i_START) begin
            row <= '0;
            col <= '0;
          end
        end
        CHECK: begin
          k      <= '0;
          gx_acc <= '0;
          gy_acc <= '0;
          if (is_border) res_data <= '0;
        end
        FETCH: k <= k + 4'd1;
        // --- stage p1: final sums -> saturated magnitude -------------------
        CALC: res_data <= sat_mag(gx_acc, gy_acc);
        OUT: begin
          if (handshake) begin
            if (col == COL_W'(IMG_W - 1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
      // Only the FETCH cycles after the first read and DRAIN see vld_p0.
      if (vld_p0) begin
        gx_acc <= gx_acc + sobel_term(tap_p0, bus.i_DATA, 1'b0);
        gy_acc <= gy_acc + sobel_term(tap_p0, bus.i_DATA, 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_engine.sv
module tb_sobel_window_engine;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 12;
  localparam int INTERIOR_READS = (W - 2) * (H - 2) * 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_window_engine_if #(.DATA_W(DW)) bus ();

  sobel_window_engine #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } exp_t;

  typedef struct {
    int          pat;
    int          r;
    int          c;
    logic [11:0] exp;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[14];
  logic [11:0] got[5][H][W];

  int n_chk  = 0;
  int n_fail = 0;
  int cur_pat = 0;
  int cyc = 0;
  int n_reads, n_done, n_viol, n_res, lat, t_hs;
  bit frame_end;
  bit hold_pend = 0;
  bit prev_valid = 0;
  logic [16:0] hold_a;
  logic [11:0] hold_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 12'd100;
      1:       return 12'(c);
      2:       return 12'(2 * r);
      3:       return (c >= W / 2) ? 12'hFFF : 12'h000;
      default: return 12'(((r * c * 577) + (r * 1231) + (c * 3001)) ^ (r << 7));
    endcase
  endfunction

  function automatic logic [11:0] model(input int pat, input int r, input int c);
    int wx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int wy[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int gx = 0;
    int gy = 0;
    int mag;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 12'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        gx += wx[i][j] * int'(pix(pat, r - 1 + i, c - 1 + j));
        gy += wy[i][j] * int'(pix(pat, r - 1 + i, c - 1 + j));
      end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 4095) ? 12'hFFF : 12'(mag);
  endfunction

  function automatic logic [16:0] paddr(input int r, input int c);
    return {8'(r), 9'(c)};
  endfunction

  // Frame-buffer model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (bus.o_READ)
      bus.i_DATA <= pix(cur_pat, int'(bus.o_ADDRESS[16:9]), int'(bus.o_ADDRESS[8:0]));
    else
      bus.i_DATA <= 12'($urandom);
  end

  // Monitor / scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   r, c;
    cyc++;
    if (!rst) begin
      if (bus.o_READ) n_reads++;
      if (!bus.o_READ && bus.o_ADDRESS != 17'd0) n_viol++;
      if (bus.o_DONE) n_done++;
      if (hold_pend)
        check("valid_hold", 32'({bus.o_PIX_VALID, bus.o_PIX_ADDR, bus.o_PIX_DATA}),
              32'({1'b1, hold_a, hold_d}));
      hold_pend = 0;
      if (bus.o_PIX_VALID && !prev_valid && bus.o_PIX_ADDR == 17'h00201) lat = cyc - t_hs;
      if (bus.o_PIX_VALID && bus.i_PIX_READY) begin
        if (bus.o_PIX_ADDR == 17'h00200) t_hs = cyc;
        n_res++;
        if (sbq.size() == 0) begin
          check("sb_unexpected_result", 32'(bus.o_PIX_ADDR), 32'h1FFFF);
        end else begin
          e = sbq.pop_front();
          check("sb_addr", 32'(bus.o_PIX_ADDR), 32'(e.addr));
          check("sb_data", 32'(bus.o_PIX_DATA), 32'(e.data));
        end
        r = int'(bus.o_PIX_ADDR[16:9]);
        c = int'(bus.o_PIX_ADDR[8:0]);
        if (r < H && c < W) got[cur_pat][r][c] = bus.o_PIX_DATA;
      end else if (bus.o_PIX_VALID) begin
        hold_pend = 1;
        hold_a    = bus.o_PIX_ADDR;
        hold_d    = bus.o_PIX_DATA;
      end
      prev_valid = bus.o_PIX_VALID;
    end else begin
      prev_valid = 0;
    end
  end

  task automatic arm_frame(input int pat);
    exp_t e;
    cur_pat = pat;
    sbq.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.addr = paddr(r, c);
        e.data = model(pat, r, c);
        sbq.push_back(e);
      end
    n_reads = 0; n_done = 0; n_viol = 0; n_res = 0; lat = -1; t_hs = 0;
    frame_end = 0;
    @(posedge clk); #1 bus.i_START = 1'b1;
    @(posedge clk); #1 bus.i_START = 1'b0;
    check("busy_after_start", 32'(bus.o_BUSY), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (bus.o_DONE) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else       check("busy_low_at_done", 32'(bus.o_BUSY), 32'd0);
    frame_end = 1;
  endtask

  task automatic stall_sequence();
    bit found;
    logic [16:0] pa;
    logic [11:0] pd;
    bus.i_PIX_READY = 1'b1;
    found = 0;
    for (int i = 0; i < 3000 && !frame_end; i++) begin
      @(posedge clk); #1;
      if (bus.o_READ && bus.o_PIX_ADDR == 17'h00201) begin found = 1; break; end
    end
    check("stall_arm", 32'(found), 32'd1);
    bus.i_PIX_READY = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.o_PIX_VALID) begin found = 1; break; end
    end
    check("stall_valid", 32'(found), 32'd1);
    pa = bus.o_PIX_ADDR;
    pd = bus.o_PIX_DATA;
    check("stall_addr", 32'(pa), 32'h00201);
    check("stall_data", 32'(pd), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_hold", 32'({bus.o_PIX_VALID, bus.o_PIX_ADDR, bus.o_PIX_DATA}),
            32'({1'b1, pa, pd}));
      check("stall_no_read", 32'(bus.o_READ), 32'd0);
    end
    bus.i_PIX_READY = 1'b1;
    @(posedge clk); #1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.o_PIX_VALID) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("after_stall_addr", 32'(found ? bus.o_PIX_ADDR : 17'h1FFFF), 32'h00202);
    while (!frame_end) @(posedge clk);
  endtask

  task automatic drive_ready(input int mode);
    int cnt = 0;
    case (mode)
      1: begin
        while (!frame_end) begin
          @(posedge clk); #1;
          bus.i_PIX_READY = 1'($urandom_range(0, 1));
        end
        bus.i_PIX_READY = 1'b1;
      end
      2: stall_sequence();
      3: begin
        bus.i_PIX_READY = 1'b1;
        while (!frame_end) begin
          @(posedge clk); #1;
          bus.i_START = 1'b0;
          cnt++;
          if ((cnt % 37) == 0 && bus.o_BUSY) bus.i_START = 1'b1;
        end
        bus.i_START = 1'b0;
      end
      default: begin
        bus.i_PIX_READY = 1'b1;
        while (!frame_end) @(posedge clk);
      end
    endcase
  endtask

  task automatic run_frame(input int pat, input int mode);
    bus.i_PIX_READY = 1'b1;
    arm_frame(pat);
    fork
      wait_done();
      drive_ready(mode);
    join
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("p%0d_results", pat), 32'(n_res), 32'(W * H));
    check($sformatf("p%0d_queue_left", pat), 32'(sbq.size()), 32'd0);
    check($sformatf("p%0d_reads", pat), 32'(n_reads), 32'(INTERIOR_READS));
    check($sformatf("p%0d_done_pulses", pat), 32'(n_done), 32'd1);
    check($sformatf("p%0d_addr_idle_nonzero", pat), 32'(n_viol), 32'd0);
    check($sformatf("p%0d_latency", pat), 32'(lat), 32'd13);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     32'(bus.o_BUSY), 32'd0);
    check({tag, "_done"},     32'(bus.o_DONE), 32'd0);
    check({tag, "_read"},     32'(bus.o_READ), 32'd0);
    check({tag, "_address"},  32'(bus.o_ADDRESS), 32'd0);
    check({tag, "_valid"},    32'(bus.o_PIX_VALID), 32'd0);
    check({tag, "_pix_data"}, 32'(bus.o_PIX_DATA), 32'd0);
    check({tag, "_pix_addr"}, 32'(bus.o_PIX_ADDR), 32'd0);
  endtask

  task automatic reset_mid_frame();
    bit found = 0;
    bus.i_PIX_READY = 1'b1;
    arm_frame(1);
    // Centre read of pixel (2,3) is its tap 4.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.o_READ && bus.o_PIX_ADDR == paddr(2, 3) && bus.o_ADDRESS == paddr(2, 3)) begin
        found = 1;
        break;
      end
    end
    check("rst_arm_k4", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("rst_mid");
    rst = 1'b0;
    sbq.delete();
    n_done = 0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_stays_idle", 32'({bus.o_BUSY, bus.o_PIX_VALID, bus.o_READ}), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0, 2, 3, 12'd0};
    tbl[1]  = '{0, 0, 0, 12'd0};
    tbl[2]  = '{1, 1, 1, 12'd8};
    tbl[3]  = '{1, 4, 6, 12'd8};
    tbl[4]  = '{1, 0, 3, 12'd0};
    tbl[5]  = '{1, 5, 7, 12'd0};
    tbl[6]  = '{2, 1, 1, 12'd16};
    tbl[7]  = '{2, 4, 5, 12'd16};
    tbl[8]  = '{2, 2, 0, 12'd0};
    tbl[9]  = '{3, 1, 3, 12'd4095};
    tbl[10] = '{3, 4, 4, 12'd4095};
    tbl[11] = '{3, 2, 2, 12'd0};
    tbl[12] = '{3, 3, 5, 12'd0};
    tbl[13] = '{3, 0, 4, 12'd0};
    for (int p = 0; p < 5; p++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) got[p][r][c] = 12'hBAD;

    rst             = 1'b1;
    bus.i_START     = 1'b0;
    bus.i_PIX_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    run_frame(0, 0);   // uniform
    run_frame(1, 2);   // horizontal ramp with a stall at (1,1)
    run_frame(2, 0);   // vertical ramp
    run_frame(3, 1);   // step edge, random backpressure
    run_frame(4, 1);   // pseudo-random image, random backpressure
    reset_mid_frame();
    run_frame(4, 3);   // restart after reset, stray starts while busy

    for (int i = 0; i < 14; i++)
      check($sformatf("tbl%0d_p%0d_r%0d_c%0d", i, tbl[i].pat, tbl[i].r, tbl[i].c),
            32'(got[tbl[i].pat][tbl[i].r][tbl[i].c]), 32'(tbl[i].exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_engine.md
Name: sobel_window_engine

Overview:
- Downstream consumer of the 320x240 frame-buffer pixel store (12-bit pixels, 17-bit address = row[16:9] | col[8:0]).
- On i_START, walks the frame in raster order. For each interior pixel it issues nine reads of the 3x3 neighbourhood, computes the Sobel gradient magnitude |Gx|+|Gy| and saturates it to 12 bits.
- Emits one result per pixel, with its address, over a valid/ready stream to the edge-map writer. Border pixels emit 0 and cause no reads.

Parameters:
- IMG_W, 320, pixels per row (column field 9 bits)
- IMG_H, 240, rows per frame (row field 8 bits)
- DATA_W, 12, pixel and result width

Ports:
- i_CLK  in  1  single clock, all logic on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_START  in  1  one-cycle pulse; starts a frame pass; ignored while o_BUSY=1
- o_BUSY  out  1  high from the cycle after an accepted i_START until o_DONE
- o_DONE  out  1  one-cycle pulse after the last pixel (239,319) handshakes
- o_READ  out  1  frame-buffer read strobe
- o_ADDRESS  out  17  frame-buffer read address {row[7:0], col[8:0]}
- i_DATA  in  DATA_W  frame-buffer read data, valid exactly 1 cycle after the o_READ cycle
- o_PIX_VALID  out  1  result valid
- i_PIX_READY  in  1  downstream accepts when high with o_PIX_VALID
- o_PIX_DATA  out  DATA_W  gradient magnitude
- o_PIX_ADDR  out  17  address of the result pixel, same packing

Behaviour:
- Reset (i_RST=1 at a rising edge):
  - All outputs go to 0 and the FSM goes to IDLE; row/col counters, fetch counter and accumulators clear.
  - Applies mid-frame too: the pass is abandoned, no o_DONE, o_READ drops on the next edge.
  - Any in-flight i_DATA is discarded.
- FSM states: IDLE, CHECK, FETCH, DRAIN, CALC, OUT, DONE.
- IDLE: i_START=1 -> CHECK with row=0, col=0, o_BUSY=1.
- CHECK:
  - Border pixel (row=0, row=IMG_H-1, col=0 or col=IMG_W-1): result=0, go to OUT, no read.
  - Otherwise go to FETCH with k=0.
- FETCH:
  - o_READ=1 for 9 consecutive cycles.
  - k=0..8 addresses (row-1+k/3, col-1+k%3), row-major.
  - After k=8 -> DRAIN, where o_READ=0.
- Capture: i_DATA is captured the cycle after each read; tap k arrives one cycle after read k. The DRAIN cycle captures tap 8.
- Weights:
  - Gx by tap: -1,0,+1,-2,0,+2,-1,0,+1.
  - Gy by tap: -1,-2,-1,0,0,0,+1,+2,+1.
  - Accumulators are 15-bit signed (range +/-16380); pixels are zero-extended to unsigned.
- CALC: mag = |Gx|+|Gy| (16-bit unsigned); o_PIX_DATA = mag>4095 ? 4095 : mag[11:0].
- OUT:
  - o_PIX_VALID=1; o_PIX_DATA and o_PIX_ADDR hold stable until i_PIX_READY=1.
  - On handshake, advance col; at col=IMG_W-1 wrap col to 0 and increment row.
  - After (IMG_H-1, IMG_W-1) go to DONE; otherwise return to CHECK.
  - o_PIX_VALID may not drop without a handshake.
- DONE: o_DONE=1 for one cycle, o_BUSY=0, -> IDLE.
- Latency:
  - Interior pixel: CHECK(1) + FETCH(9) + DRAIN(1) + CALC(1) = o_PIX_VALID 12 cycles after entering CHECK, with ready held high.
  - Border pixel: valid 1 cycle after CHECK.
- Read strobe: o_READ is never asserted outside FETCH; o_ADDRESS=0 when o_READ=0.
- i_START while busy has no effect.

Test Plan:
- Uniform frame, all pixels 100, ready tied high:
  - 76800 results, all o_PIX_DATA=0.
  - Exactly 318*238*9 = 681156 read strobes, then a single o_DONE.
- Horizontal ramp, pixel = col:
  - Interior results = 8 (Gx=8, Gy=0); borders = 0.
  - Result at (1,1) carries o_PIX_ADDR=0x00201.
- Vertical ramp, pixel = 2*row: interior results = 16.
- Step edge, pixel = (col>=160) ? 4095 : 0:
  - (r,159) and (r,160) give Gx=16380, saturating to o_PIX_DATA=4095.
  - Other interior results = 0.
- Backpressure: i_PIX_READY low for 5 cycles at pixel (1,1).
  - o_PIX_VALID, data and address stay stable; no o_READ during the stall.
  - Result (1,2) follows the release.
- Reset and start handling:
  - i_RST at FETCH k=4 of pixel (10,10): next cycle all outputs 0 and IDLE, no o_DONE.
  - A new i_START restarts from (0,0).
  - i_START during a pass is ignored.
